uart_tx: RTL and testbench

- UART transmitter that sits directly downstream of the baud generator and consumes its square-wave `baud_out` as the bit-rate reference.
- Accepts one parallel byte per request and serialises it LSB-first as start bit, data bits, optional parity bit, then stop bit(s).
- Drives the serial line to the board pin; all logic runs in the single system clock domain.

---
 rtl/uart_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s), timed by baud_in rising edges.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen by PARITY_ODD).
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_in,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // state  | meaning
    // IDLE   | line high, waiting for a request
    // ARM    | request latched, waiting for a tick to align the start bit
    // START  | start bit (low) on the line
    // DATA   | data bit (bit_idx - 1) on the line
    // PARITY | parity bit on the line
    // STOP   | stop bit number stop_cnt on the line
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;
`endif

    localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS);

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [3:0]             idx_q, idx_d;
    logic [1:0]             stop_q, stop_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   baud_q;
    logic                   tick;

`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`else
    logic                   unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign tick = baud_in & ~baud_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            stop_q   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            baud_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            baud_q   <= baud_in;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // done_q marks the first IDLE cycle; a request there waits one clk
                if (tx_start && !done_q) begin
                    shift_d  = tx_data;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    state_d  = ARM;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            ARM: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = 4'd1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q < LAST_IDX) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 4'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        stop_d  = 2'd1;
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    stop_d  = 2'd1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (stop_q < LAST_STOP) begin
                        stop_d = stop_q + 2'd1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: requested bytes are queued, a line monitor decodes each frame and compares.
module tb_uart_tx;

    localparam int P       = 20;
    localparam int DB      = 8;
    localparam int PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int PB = 1;
`else
    localparam int SB = 1;
    localparam int PB = 0;
`endif
    localparam int NB = 1 + DB + PB + SB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_in = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_busy, tx_done;

    uart_tx #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PAR_ODD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_in  (baud_in),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int frames = 0;
    int done_pulses = 0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // baud square wave, period P clk, high for the first half
    initial begin
        int c = 0;
        forever begin
            @(negedge clk);
            c = (c + 1) % P;
            baud_in = (c < P / 2);
        end
    end

    // line monitor: detects the start-bit falling edge and samples mid-bit
    initial begin
        bit         rx = 0;
        int         k = 0;
        logic       prev = 1'b1;
        logic [7:0] exp_byte;
        logic [15:0] bits;
        forever begin
            @(negedge clk);
            if (tx_done === 1'b1) done_pulses++;
            if (!rst_n) begin
                rx = 0;
            end else if (!rx) begin
                if (prev === 1'b1 && tx === 1'b0) begin
                    rx = 1;
                    k  = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_frame", sb.size(), 1);
                        exp_byte = 8'h00;
                    end else begin
                        exp_byte = sb.pop_front();
                    end
                    bits    = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < DB; i++) bits[1+i] = exp_byte[i];
`ifdef UART_TX_PARITY_EN
                    bits[1+DB] = (^exp_byte) ^ PAR_ODD[0];
`endif
                end
            end else begin
                k++;
                if (k % P == P / 2 && k / P < NB) begin
                    check($sformatf("byte%02h_bit%0d", exp_byte, k / P), tx, bits[k / P]);
                    check("busy_in_frame", tx_busy, 1);
                end
                if (k == NB * P - 1) check("done_early", tx_done, 0);
                if (k == NB * P) begin
                    check($sformatf("byte%02h_done", exp_byte), tx_done, 1);
                    check("busy_clear", tx_busy, 0);
                    check("tx_idle_after", tx, 1);
                    rx = 0;
                    frames++;
                end
            end
            prev = tx;
        end
    end

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames < n && t < 3 * NB * P) begin
            @(negedge clk);
            t++;
        end
        check("frames_completed", frames, n);
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        int lat = 0;
        tx_data  = d;
        tx_start = 1'b1;
        sb.push_back(d);
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_on_accept", tx_busy, 1);
        while (tx !== 1'b0 && lat < 3 * P) begin
            @(negedge clk);
            lat++;
        end
        check("start_latency_ok", (lat >= 1 && lat <= P + 1), 1);
    endtask

    initial begin
        int lows = 0;
        int t = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        rst_n = 1'b1;

        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("idle_low_samples", lows, 0);

        send(8'hA5);
        wait_frames(1);

        // request mid-frame must be dropped
        send(8'hA5);
        repeat (4 * P) @(negedge clk);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_frames(2);
        repeat (NB * P) @(negedge clk);
        check("no_extra_frame", frames, 2);

        // back-to-back with tx_start held through tx_done
        tx_data  = 8'h00;
        tx_start = 1'b1;
        sb.push_back(8'h00);
        @(negedge clk);
        check("b2b_first_busy", tx_busy, 1);
        tx_data = 8'hFF;
        sb.push_back(8'hFF);
        t = 0;
        while (tx_done !== 1'b1 && t < 3 * NB * P) begin
            @(negedge clk);
            t++;
        end
        check("b2b_done_seen", tx_done, 1);
        @(negedge clk);
        check("b2b_reject_in_done_cycle", tx_busy, 0);
        @(negedge clk);
        check("b2b_accept_next", tx_busy, 1);
        tx_start = 1'b0;
        wait_frames(4);

        // reset during data bit 3
        send(8'h0F);
        repeat (4 * P + P / 2 + 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", tx, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_done", tx_done, 0);
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h0F);
        wait_frames(5);

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        wait_frames(6);
        send(8'h03);
        wait_frames(7);
`endif

        check("scoreboard_empty", sb.size(), 0);
        check("done_pulse_count", done_pulses, frames);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
